mdu_divider: RTL and testbench
==============================

Name: mdu_divider

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage of the MIPS core.
- Serves the DIV and DIVU operations that the ALU decoder signals via DIV_CONTROL and DIVU_CONTROL.
- Raises a stall toward the pipeline while iterating, then presents quotient and remainder for the HI/LO write.
- Parametrised in operand width. It also adds divide-by-zero flagging and mid-operation annul for exception flush.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (minimum 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a division; sampled in IDLE only
signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
annul  input  1  flush: abandon any in-flight or requested division
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
stall  output  1  hold the pipeline
result_valid  output  1  one-cycle pulse when quotient and remainder are new
quotient  output  WIDTH  quotient (goes to LO)
remainder  output  WIDTH  remainder (goes to HI)
div_by_zero  output  1  the last completed operation had divisor == 0

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; quotient, remainder and div_by_zero = 0; result_valid = 0. Reset mid-RUN aborts the operation immediately.
- States: IDLE, RUN, DONE.
- An operation is accepted when state == IDLE, start = 1 and annul = 0.
- stall is combinational: stall = (IDLE & start & ~annul) | RUN. stall = 0 in DONE.
- IDLE -> RUN on accept with divisor != 0. Operands are latched, the iteration counter is loaded with WIDTH, and the sign flags are captured.
- IDLE -> DONE on accept with divisor == 0. Next cycle: quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN: one restoring step per cycle on the unsigned magnitudes.
  - Shift {partial_rem, q} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1 bit subtractor.
  - If the result is non-negative, keep it and set the q LSB to 1.
  - The counter decrements each step. After WIDTH steps -> DONE.
- DONE (exactly one cycle): result_valid = 1, quotient and remainder registered. Then -> IDLE unconditionally.
- Latency: start accepted at edge T. The result is registered and result_valid is high in cycle T+WIDTH+1 (divide-by-zero: T+1). stall is high for cycles T through T+WIDTH inclusive.
- Signed mode:
  - Magnitudes are the two's-complement absolute values. Treat as WIDTH-bit unsigned, so abs(min_int) = 2^(WIDTH-1) is exact.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - min_int / -1: quotient = min_int (wraps), remainder = 0, div_by_zero = 0.
- Unsigned mode: no sign correction.
- quotient, remainder and div_by_zero hold their values until the next DONE. They are not cleared in IDLE.
- annul:
  - In RUN: next state IDLE, no DONE, no result_valid, outputs unchanged.
  - Coincident with start in IDLE: no accept, stall = 0.
  - In DONE: ignored; the result still completes.
- start while in RUN or DONE is ignored. The pipeline must reissue after stall drops.
- Back-to-back: a start during the IDLE cycle after DONE is accepted normally. There is no start-to-accept in DONE itself.

Test Plan:
- WIDTH=32, unsigned 100 / 7 at T -> stall high T..T+32; result_valid at T+33 with quotient=14, remainder=2, div_by_zero=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned of the same operands -> quotient=0, remainder=0x80000000.
- Divisor 0, dividend 0x1234 -> result_valid at T+1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, stall high only in cycle T.
- Annul asserted at T+10 of a run -> IDLE at T+11, no result_valid, quotient/remainder keep their previous values. rst asserted mid-run -> all outputs 0 next cycle.
- WIDTH=8 build, unsigned 0xFF / 0x10 -> result_valid at T+9, quotient=0x0F, remainder=0x0F. Then start in the IDLE cycle right after DONE -> accepted.

Source files
------------

// File: rtl/mdu_divider_if.sv
// Execute-stage divider request/response bundle shared by the pipeline and mdu_divider.
// The master is the pipeline side; the slave is the divider.
interface mdu_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  stall, result_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output stall, result_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// operand magnitudes, sign fix-up on completion, divide-by-zero short path and annul.
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    mdu_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dz;
    logic             r_valid;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_pr;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    always_comb begin
        w_accept = (r_state == S_IDLE) && bus.start && !bus.annul;
        w_a_neg  = bus.signed_div && bus.dividend[WIDTH-1];
        w_b_neg  = bus.signed_div && bus.divisor[WIDTH-1];
        // Magnitudes are WIDTH-bit unsigned, so |min_int| = 2^(WIDTH-1) stays exact.
        w_a_mag  = w_a_neg ? -bus.dividend : bus.dividend;
        w_b_mag  = w_b_neg ? -bus.divisor  : bus.divisor;

        w_pr   = {r_rem, r_q[WIDTH-1]};
        w_diff = w_pr - {1'b0, r_dvs};
        if (!w_diff[WIDTH]) begin
            w_rem_nxt = w_diff[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_pr[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_remd  <= '0;
            r_dz    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.divisor == '0) begin
                            r_quot  <= '1;
                            r_remd  <= bus.dividend;
                            r_dz    <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_cnt   <= CW'(WIDTH);
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_q   <= w_q_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        // Final step: publish sign-corrected results straight from the step logic.
                        if (r_cnt == CW'(1)) begin
                            r_quot  <= r_neg_q ? -w_q_nxt : w_q_nxt;
                            r_remd  <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
                            r_dz    <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall        = w_accept || (r_state == S_RUN);
    assign bus.result_valid = r_valid;
    assign bus.quotient     = r_quot;
    assign bus.remainder    = r_remd;
    assign bus.div_by_zero  = r_dz;
endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: 32-bit and 8-bit instances, directed corner cases
// plus random operands checked against plain-arithmetic division.
module tb_mdu_divider;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_divider_if #(.WIDTH(32)) b32 ();
    mdu_divider_if #(.WIDTH(8))  b8 ();

    mdu_divider #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    mdu_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t        sb32[$];
    exp_t        sb8[$];
    exp_t        m32;
    exp_t        m8;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_q32 = '0;
    logic [31:0] last_r32 = '0;
    logic        last_dz32 = 1'b0;

    // Truncating division on mathematical integers, reduced to w bits.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint mask;
        longint sa;
        longint sb;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (sb == 0) begin
            e.q  = 32'(mask);
            e.r  = 32'(sa);
            e.dz = 1'b1;
            return e;
        end
        if (sg) begin
            if (sa[w-1]) sa = sa - (longint'(1) << w);
            if (sb[w-1]) sb = sb - (longint'(1) << w);
        end
        e.q  = 32'((sa / sb) & mask);
        e.r  = 32'((sa % sb) & mask);
        e.dz = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && b32.result_valid === 1'b1) begin
            if (sb32.size() == 0) begin
                check("unexpected_valid32", 32'(b32.result_valid), 32'd0);
            end else begin
                m32 = sb32.pop_front();
                check("quotient32", b32.quotient, m32.q);
                check("remainder32", b32.remainder, m32.r);
                check("dz32", 32'(b32.div_by_zero), 32'(m32.dz));
                last_q32  = m32.q;
                last_r32  = m32.r;
                last_dz32 = m32.dz;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && b8.result_valid === 1'b1) begin
            if (sb8.size() == 0) begin
                check("unexpected_valid8", 32'(b8.result_valid), 32'd0);
            end else begin
                m8 = sb8.pop_front();
                check("quotient8", {24'd0, b8.quotient}, m8.q);
                check("remainder8", {24'd0, b8.remainder}, m8.r);
                check("dz8", 32'(b8.div_by_zero), 32'(m8.dz));
            end
        end
    end

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit sg, input bit poke);
        int lat;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        b32.start = 1'b1; b32.signed_div = sg; b32.dividend = a; b32.divisor = b;
        #1 check("stall_accept32", 32'(b32.stall), 32'd1);
        sb32.push_back(model(32, a, b, sg));
        @(negedge clk);
        b32.start = 1'b0; b32.dividend = $urandom; b32.divisor = $urandom; b32.signed_div = ~sg;
        lat = 1;
        while (b32.result_valid !== 1'b1 && lat < 40) begin
            check("stall_run32", 32'(b32.stall), 32'd1);
            @(negedge clk);
            lat++;
            b32.start = (poke && lat == 5);
        end
        b32.start = 1'b0;
        check("latency32", 32'(lat), 32'(exp_lat));
        check("stall_done32", 32'(b32.stall), 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sg, input bit b2b);
        int lat;
        int exp_lat;
        exp_lat = (b == 8'd0) ? 1 : 9;
        if (b2b) begin
            // Called in the DONE cycle: the request must wait for the following IDLE cycle.
            b8.start = 1'b1; b8.signed_div = sg; b8.dividend = a; b8.divisor = b;
            #1 check("stall_done_start8", 32'(b8.stall), 32'd0);
            @(negedge clk);
        end else begin
            @(negedge clk);
            b8.start = 1'b1; b8.signed_div = sg; b8.dividend = a; b8.divisor = b;
        end
        #1 check("stall_accept8", 32'(b8.stall), 32'd1);
        sb8.push_back(model(8, {24'd0, a}, {24'd0, b}, sg));
        @(negedge clk);
        b8.start = 1'b0; b8.dividend = 8'($urandom); b8.divisor = 8'($urandom);
        lat = 1;
        while (b8.result_valid !== 1'b1 && lat < 16) begin
            check("stall_run8", 32'(b8.stall), 32'd1);
            @(negedge clk);
            lat++;
        end
        check("latency8", 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_held32(input string tag);
        check({tag, "_q"}, b32.quotient, last_q32);
        check({tag, "_r"}, b32.remainder, last_r32);
        check({tag, "_dz"}, 32'(b32.div_by_zero), 32'(last_dz32));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        b32.start = 1'b0; b32.signed_div = 1'b0; b32.annul = 1'b0; b32.dividend = '0; b32.divisor = '0;
        b8.start  = 1'b0; b8.signed_div  = 1'b0; b8.annul  = 1'b0; b8.dividend  = '0; b8.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(b32.result_valid), 32'd0);
        check("rst_stall", 32'(b32.stall), 32'd0);
        check_held32("rst");
        rst = 1'b0;

        op32(32'd100, 32'd7, 1'b0, 1'b0);
        op32(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        op32(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op32(32'h0000_1234, 32'd0, 1'b0, 1'b0);
        op32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        op32(32'hDEAD_BEEF, 32'h0001_0000, 1'b1, 1'b0);

        // Annul ten cycles into a run: no result, outputs hold.
        @(negedge clk);
        b32.start = 1'b1; b32.signed_div = 1'b0; b32.dividend = 32'd999; b32.divisor = 32'd3;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (9) @(negedge clk);
        b32.annul = 1'b1;
        #1 check("stall_annul_cycle", 32'(b32.stall), 32'd1);
        @(negedge clk);
        b32.annul = 1'b0;
        #1 check("stall_after_annul", 32'(b32.stall), 32'd0);
        repeat (40) @(negedge clk);
        check_held32("annul_hold");

        // Annul coincident with start: nothing accepted.
        b32.start = 1'b1; b32.annul = 1'b1; b32.dividend = 32'd50; b32.divisor = 32'd5;
        #1 check("stall_start_annul", 32'(b32.stall), 32'd0);
        @(negedge clk);
        b32.start = 1'b0; b32.annul = 1'b0;
        #1 check("stall_no_accept", 32'(b32.stall), 32'd0);
        repeat (40) @(negedge clk);
        check_held32("noacc_hold");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            op32(a, b, 1'($urandom), 1'b0);
        end

        // Reset in the middle of a run clears every output.
        @(negedge clk);
        b32.start = 1'b1; b32.signed_div = 1'b1; b32.dividend = 32'd12345; b32.divisor = 32'd17;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_q32 = '0; last_r32 = '0; last_dz32 = 1'b0;
        sb32.delete();
        check("midrst_valid", 32'(b32.result_valid), 32'd0);
        check("midrst_stall", 32'(b32.stall), 32'd0);
        check_held32("midrst");
        repeat (40) @(negedge clk);

        op8(8'hFF, 8'h10, 1'b0, 1'b0);
        op8(8'h81, 8'h07, 1'b1, 1'b1);
        op8(8'h80, 8'hFF, 1'b1, 1'b1);
        op8(8'h5A, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
        end
        repeat (4) @(negedge clk);
        check("sb32_drained", 32'(sb32.size()), 32'd0);
        check("sb8_drained", 32'(sb8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
